hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage in-order core. Drives stall/flush of the F/D, D/E, E/M, M/W

---
 rtl/hazard_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage in-order core.
// Generates stall/flush controls for the F/D, D/E, E/M and M/W registers,
// E-stage forwarding selects, and the start/wait handshake with the
// multi-cycle mul/div unit and the wait-stated data memory.
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int SCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // D-stage sources
  input  logic [4:0]        ad1d,
  input  logic [4:0]        ad2d,
  // E-stage sources
  input  logic [4:0]        ad1e,
  input  logic [4:0]        ad2e,
  // destinations in E/M/W
  input  logic [4:0]        rde,
  input  logic [4:0]        rdm,
  input  logic [4:0]        rdw,
  input  logic [1:0]        resltSrce,
  input  logic              regWrtm,
  input  logic              regWrtw,
  input  logic              pcSrce,
  // multi-cycle unit / data memory handshake
  input  logic              mcOpe,
  input  logic              mcDone,
  input  logic              memReqm,
  input  logic              memRdym,
  // stage controls
  output logic              stallf,
  output logic              stalld,
  output logic              stalle,
  output logic              stallm,
  output logic              flushd,
  output logic              flushe,
  output logic              flushm,
  output logic              flushw,
  // forwarding selects
  output logic [1:0]        fwdAe,
  output logic [1:0]        fwdBe,
  // multi-cycle unit control and status
  output logic              mcGoe,
  output logic              mcErr,
  output logic [SCNT_W-1:0] stallCnt
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MC_WAIT  = 2'd2;

  // Timer must be able to hold MC_TIMEOUT-1; keep at least one bit.
  localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);
  localparam logic [SCNT_W-1:0] CNT_MAX = {SCNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Registered state and its next-state values
  // ---------------------------------------------------------------------------
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [TW-1:0]     timer_reg;
  logic [TW-1:0]     timer_next;
  logic              err_reg;
  logic              err_next;
  logic [SCNT_W-1:0] cnt_reg;

  // ---------------------------------------------------------------------------
  // Hazard detection terms
  // ---------------------------------------------------------------------------
  logic mem_block;   // M-stage memory access not yet acknowledged
  logic load_use;    // load in E feeds a source of the instruction in D
  logic mc_timeout;  // last permitted wait cycle of the multi-cycle op

  // Memory back-pressure only matters while the M stage holds a real access.
  assign mem_block = memReqm && !memRdym;

  // A load writing x0 never creates a dependency.
  assign load_use = (resltSrce == 2'b01) && (rde != 5'd0) &&
                    ((rde == ad1d) || (rde == ad2d));

  assign mc_timeout = (timer_reg == TIMER_LAST);

  // ---------------------------------------------------------------------------
  // Operand forwarding: one identical selector per E-stage source operand.
  // The M stage holds the younger result, so it wins over W.
  // ---------------------------------------------------------------------------
  logic [9:0] src_e;
  logic [3:0] fwd_sel;

  assign src_e = {ad2e, ad1e};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_m;
      logic hit_w;
      assign hit_m = regWrtm && (rdm != 5'd0) && (rdm == src_e[gi*5 +: 5]);
      assign hit_w = regWrtw && (rdw != 5'd0) && (rdw == src_e[gi*5 +: 5]);
      assign fwd_sel[gi*2 +: 2] = hit_m ? 2'b10 :
                                  hit_w ? 2'b01 : 2'b00;
    end
  endgenerate

  // Forwarding is quiet while reset is held so the E stage sees register-file data.
  assign fwdAe = rst_n ? fwd_sel[1:0] : 2'b00;
  assign fwdBe = rst_n ? fwd_sel[3:2] : 2'b00;

  // ---------------------------------------------------------------------------
  // Next-state and stage-control decode
  // ---------------------------------------------------------------------------
  // Stage controls are a pure function of the current state and inputs.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    stallf     = 1'b0;
    stalld     = 1'b0;
    stalle     = 1'b0;
    stallm     = 1'b0;
    flushd     = 1'b0;
    flushe     = 1'b0;
    flushm     = 1'b0;
    flushw     = 1'b0;
    mcGoe      = 1'b0;

    case (state_reg)
      // MEM_WAIT with a ready memory behaves exactly like RUN, so both
      // share one decode; the only difference is where a blocked access
      // came from.
      RUN, MEM_WAIT: begin
        if (mem_block) begin
          // Freeze everything up to M; W gets a bubble. A multi-cycle op
          // waiting in E is not started until memory releases the pipe.
          stallf     = 1'b1;
          stalld     = 1'b1;
          stalle     = 1'b1;
          stallm     = 1'b1;
          flushw     = 1'b1;
          state_next = MEM_WAIT;
        end else if (mcOpe) begin
          // Launch the mul/div and hold E; M receives bubbles meanwhile.
          mcGoe      = 1'b1;
          stallf     = 1'b1;
          stalld     = 1'b1;
          stalle     = 1'b1;
          flushm     = 1'b1;
          timer_next = '0;
          state_next = MC_WAIT;
        end else begin
          state_next = RUN;
          if (load_use) begin
            // One bubble: hold F/D, clear D/E.
            stallf = 1'b1;
            stalld = 1'b1;
            flushe = 1'b1;
          end else if (pcSrce) begin
            // Kill the two wrong-path instructions behind the branch.
            flushd = 1'b1;
            flushe = 1'b1;
          end
        end
      end

      MC_WAIT: begin
        // M only ever holds a bubble here, so memory requests are ignored.
        if (mcDone || mc_timeout) begin
          if (!mcDone) begin
            err_next = 1'b1;
          end
          timer_next = '0;
          state_next = RUN;
          if (pcSrce) begin
            flushd = 1'b1;
            flushe = 1'b1;
          end
        end else begin
          stallf     = 1'b1;
          stalld     = 1'b1;
          stalle     = 1'b1;
          flushm     = 1'b1;
          timer_next = timer_reg + TW'(1);
        end
      end

      default: begin
        state_next = RUN;
        timer_next = '0;
      end
    endcase

    // While reset is held the front of the pipe is cleared and nothing else moves.
    if (!rst_n) begin
      stallf = 1'b0;
      stalld = 1'b0;
      stalle = 1'b0;
      stallm = 1'b0;
      flushd = 1'b1;
      flushe = 1'b1;
      flushm = 1'b0;
      flushw = 1'b0;
      mcGoe  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // FSM state, wait timer and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      timer_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
    end
  end

  // Saturating count of front-end stall cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (stallf && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + SCNT_W'(1);
    end
  end

  assign mcErr    = err_reg;
  assign stallCnt = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl. Inputs change on the falling edge,
// outputs are sampled 1ns later, well away from the rising edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw;
  logic [1:0]  resltSrce;
  logic        regWrtm, regWrtw, pcSrce, mcOpe, mcDone, memReqm, memRdym;
  logic        stallf, stalld, stalle, stallm;
  logic        flushd, flushe, flushm, flushw;
  logic [1:0]  fwdAe, fwdBe;
  logic        mcGoe, mcErr;
  logic [15:0] stallCnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Control vector order: stallf stalld stalle stallm flushd flushe flushm flushw mcGoe
  logic [8:0] ctrl;
  assign ctrl = {stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw, mcGoe};

  localparam logic [8:0] C_IDLE  = 9'b0000_0000_0;
  localparam logic [8:0] C_RST   = 9'b0000_1100_0;
  localparam logic [8:0] C_LU    = 9'b1100_0100_0;
  localparam logic [8:0] C_BR    = 9'b0000_1100_0;
  localparam logic [8:0] C_MEM   = 9'b1111_0001_0;
  localparam logic [8:0] C_MCGO  = 9'b1110_0010_1;
  localparam logic [8:0] C_MCW   = 9'b1110_0010_0;

  hazard_ctrl #(.MC_TIMEOUT(64), .SCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ad1d(ad1d), .ad2d(ad2d), .ad1e(ad1e), .ad2e(ad2e),
    .rde(rde), .rdm(rdm), .rdw(rdw), .resltSrce(resltSrce),
    .regWrtm(regWrtm), .regWrtw(regWrtw), .pcSrce(pcSrce),
    .mcOpe(mcOpe), .mcDone(mcDone), .memReqm(memReqm), .memRdym(memRdym),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
    .flushd(flushd), .flushe(flushe), .flushm(flushm), .flushw(flushw),
    .fwdAe(fwdAe), .fwdBe(fwdBe), .mcGoe(mcGoe), .mcErr(mcErr), .stallCnt(stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ad1d = 0; ad2d = 0; ad1e = 0; ad2e = 0; rde = 0; rdm = 0; rdw = 0;
    resltSrce = 2'b00; regWrtm = 0; regWrtw = 0; pcSrce = 0;
    mcOpe = 0; mcDone = 0; memReqm = 0; memRdym = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    // matching forwarding inputs must still give 00 under reset
    rdm = 5'd5; ad1e = 5'd5; regWrtm = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_RST) begin tests_failed++; $display("FAIL reset_ctrl got %b need %b", ctrl, C_RST); end
    else $display("[TB] reset_ctrl ok");
    tests_run++;
    if (fwdAe !== 2'b00) begin tests_failed++; $display("FAIL reset_fwd got %b need 00", fwdAe); end
    else $display("[TB] reset_fwd ok");
    tests_run++;
    if (stallCnt !== 16'd0 || mcErr !== 1'b0) begin
      tests_failed++; $display("FAIL reset_regs got cnt=%0d err=%b need 0/0", stallCnt, mcErr);
    end else $display("[TB] reset_regs ok");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || fwdAe !== 2'b10) begin
      tests_failed++; $display("FAIL reset_release got ctrl=%b fwdA=%b need %b/10", ctrl, fwdAe, C_IDLE);
    end else $display("[TB] reset_release ok");
  endtask

  task automatic test_forwarding();
    do_reset();
    @(negedge clk);
    rdm = 5'd5; rdw = 5'd5; ad1e = 5'd5; ad2e = 5'd5; regWrtm = 1; regWrtw = 1;
    #1;
    tests_run++;
    if (fwdAe !== 2'b10 || fwdBe !== 2'b10) begin
      tests_failed++; $display("FAIL fwd_m_wins got A=%b B=%b need 10/10", fwdAe, fwdBe);
    end else $display("[TB] fwd_m_wins ok");
    @(negedge clk);
    regWrtm = 0;
    #1;
    tests_run++;
    if (fwdAe !== 2'b01 || fwdBe !== 2'b01) begin
      tests_failed++; $display("FAIL fwd_w got A=%b B=%b need 01/01", fwdAe, fwdBe);
    end else $display("[TB] fwd_w ok");
    @(negedge clk);
    regWrtm = 1; rdm = 5'd0; rdw = 5'd0; ad1e = 5'd0; ad2e = 5'd0;
    #1;
    tests_run++;
    if (fwdAe !== 2'b00 || fwdBe !== 2'b00) begin
      tests_failed++; $display("FAIL fwd_x0 got A=%b B=%b need 00/00", fwdAe, fwdBe);
    end else $display("[TB] fwd_x0 ok");
    @(negedge clk);
    rdm = 5'd9; ad1e = 5'd9; rdw = 5'd12; ad2e = 5'd12; regWrtw = 1;
    #1;
    tests_run++;
    if (fwdAe !== 2'b10 || fwdBe !== 2'b01) begin
      tests_failed++; $display("FAIL fwd_split got A=%b B=%b need 10/01", fwdAe, fwdBe);
    end else $display("[TB] fwd_split ok");
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    resltSrce = 2'b01; rde = 5'd0; ad1d = 5'd0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL lu_x0 got %b need %b", ctrl, C_IDLE); end
    else $display("[TB] lu_x0 ok");
    @(negedge clk);
    rde = 5'd3; ad2d = 5'd3;
    #1;
    tests_run++;
    if (ctrl !== C_LU) begin tests_failed++; $display("FAIL lu_stall got %b need %b", ctrl, C_LU); end
    else $display("[TB] lu_stall ok");
    @(negedge clk);
    resltSrce = 2'b00; rde = 5'd0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || stallCnt !== 16'd1) begin
      tests_failed++; $display("FAIL lu_after got ctrl=%b cnt=%0d need %b/1", ctrl, stallCnt, C_IDLE);
    end else $display("[TB] lu_after ok");
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    pcSrce = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== C_BR) begin tests_failed++; $display("FAIL br_flush got %b need %b", ctrl, C_BR); end
    else $display("[TB] br_flush ok");
    @(negedge clk);
    pcSrce = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || stallCnt !== 16'd0) begin
      tests_failed++; $display("FAIL br_after got ctrl=%b cnt=%0d need %b/0", ctrl, stallCnt, C_IDLE);
    end else $display("[TB] br_after ok");
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memReqm = 1; memRdym = 0; mcOpe = 1;  // mc op must not start under mem stall
      #1;
      tests_run++;
      if (ctrl !== C_MEM) begin tests_failed++; $display("FAIL mem_stall%0d got %b need %b", i, ctrl, C_MEM); end
      else $display("[TB] mem_stall%0d ok", i);
    end
    @(negedge clk);
    memRdym = 1; mcOpe = 0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL mem_release got %b need %b", ctrl, C_IDLE); end
    else $display("[TB] mem_release ok");
    @(negedge clk);
    memReqm = 0; memRdym = 0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || stallCnt !== 16'd3) begin
      tests_failed++; $display("FAIL mem_count got ctrl=%b cnt=%0d need %b/3", ctrl, stallCnt, C_IDLE);
    end else $display("[TB] mem_count ok");
  endtask

  task automatic test_mc_done();
    do_reset();
    @(negedge clk);
    mcOpe = 1;
    #1;
    tests_run++;
    if (ctrl !== C_MCGO) begin tests_failed++; $display("FAIL mc_go got %b need %b", ctrl, C_MCGO); end
    else $display("[TB] mc_go ok");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      // memory requests are ignored while waiting; forwarding stays live
      memReqm = (i == 2); memRdym = 0;
      rdm = 5'd4; ad1e = 5'd4; regWrtm = (i == 3);
      #1;
      tests_run++;
      if (ctrl !== C_MCW) begin tests_failed++; $display("FAIL mc_wait%0d got %b need %b", i, ctrl, C_MCW); end
      else $display("[TB] mc_wait%0d ok", i);
      if (i == 3) begin
        tests_run++;
        if (fwdAe !== 2'b10) begin tests_failed++; $display("FAIL mc_fwd got %b need 10", fwdAe); end
        else $display("[TB] mc_fwd ok");
      end
    end
    @(negedge clk);
    memReqm = 0; regWrtm = 0; mcDone = 1; pcSrce = 1;
    #1;
    tests_run++;
    if (ctrl !== C_BR) begin tests_failed++; $display("FAIL mc_done got %b need %b", ctrl, C_BR); end
    else $display("[TB] mc_done ok");
    @(negedge clk);
    mcOpe = 0; mcDone = 0; pcSrce = 0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || stallCnt !== 16'd6 || mcErr !== 1'b0) begin
      tests_failed++;
      $display("FAIL mc_after got ctrl=%b cnt=%0d err=%b need %b/6/0", ctrl, stallCnt, mcErr, C_IDLE);
    end else $display("[TB] mc_after ok");
  endtask

  task automatic test_mc_timeout();
    do_reset();
    @(negedge clk);
    mcOpe = 1;
    #1;
    tests_run++;
    if (ctrl !== C_MCGO) begin tests_failed++; $display("FAIL to_go got %b need %b", ctrl, C_MCGO); end
    else $display("[TB] to_go ok");
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (ctrl !== C_MCW) begin tests_failed++; $display("FAIL to_wait%0d got %b need %b", i, ctrl, C_MCW); end
    end
    $display("[TB] to_wait loop done");
    @(negedge clk);
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || mcErr !== 1'b0) begin
      tests_failed++; $display("FAIL to_release got ctrl=%b err=%b need %b/0", ctrl, mcErr, C_IDLE);
    end else $display("[TB] to_release ok");
    @(negedge clk);
    mcOpe = 0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE || mcErr !== 1'b1 || stallCnt !== 16'd64) begin
      tests_failed++;
      $display("FAIL to_err got ctrl=%b err=%b cnt=%0d need %b/1/64", ctrl, mcErr, stallCnt, C_IDLE);
    end else $display("[TB] to_err ok");
    // a later successful op leaves the error flag set
    @(negedge clk);
    mcOpe = 1;
    @(negedge clk);
    mcDone = 1;
    @(negedge clk);
    mcOpe = 0; mcDone = 0;
    #1;
    tests_run++;
    if (mcErr !== 1'b1 || ctrl !== C_IDLE) begin
      tests_failed++; $display("FAIL to_sticky got err=%b ctrl=%b need 1/%b", mcErr, ctrl, C_IDLE);
    end else $display("[TB] to_sticky ok");
  endtask

  task automatic test_reset_midwait();
    @(negedge clk);
    mcOpe = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (ctrl !== C_MCW) begin tests_failed++; $display("FAIL rmw_pre got %b need %b", ctrl, C_MCW); end
    else $display("[TB] rmw_pre ok");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== C_RST || stallCnt !== 16'd0 || mcErr !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmw_reset got ctrl=%b cnt=%0d err=%b need %b/0/0", ctrl, stallCnt, mcErr, C_RST);
    end else $display("[TB] rmw_reset ok");
    @(negedge clk);
    rst_n = 1'b1; mcOpe = 0;
    #1;
    tests_run++;
    if (ctrl !== C_IDLE) begin tests_failed++; $display("FAIL rmw_run got %b need %b", ctrl, C_IDLE); end
    else $display("[TB] rmw_run ok");
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_mc_done();
    test_mc_timeout();
    test_reset_midwait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
